cp0_irq_ctrl: RTL and testbench

- Parametrised CP0 successor: multi-line vectored interrupt controller with STATUS/CAUSE/EPC/EHBR, free-running count with compare-match timer interrupt, and ERET.
- Register reads happen in ID; writes and ERET take effect in EXE.
- Interrupt arbitration is evaluated in MEM.
- Drives the pipeline's forced-jump path (jump_en/jump_addr).

---
 rtl/cp0_irq_ctrl_pkg.sv | 33 +++
 rtl/cp0_irq_ctrl_prio_enc.sv | 31 +++
 rtl/cp0_irq_ctrl.sv | 155 +++++++++++++++
 tb/tb_cp0_irq_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_irq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cp0_irq_ctrl_pkg
//   Shared constants for the CP0 interrupt controller: register addresses,
//   STATUS/CAUSE field offsets, CP0 operation encodings and the upper bound on
//   interrupt lines.
// -----------------------------------------------------------------------------
package cp0_irq_ctrl_pkg;

    localparam int MAX_IRQ = 16;

    // CP0 register addresses
    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;
    localparam logic [4:0] CP0_EHBR    = 5'd15;

    // STATUS / CAUSE field offsets
    localparam int STATUS_IE      = 0;
    localparam int STATUS_EXL     = 1;
    localparam int STATUS_MASK_LO = 16;
    localparam int CAUSE_ID_LO    = 2;
    localparam int CAUSE_PEND_LO  = 16;

    // CP0 operation issued by EXE
    typedef enum logic [1:0] {
        EXE_CP_NONE  = 2'd0,
        EXE_CP_STORE = 2'd1,
        EXE_CP0_ERET = 2'd2
    } cp0_oper_e;

endpackage

// File: rtl/cp0_irq_ctrl_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc
//   Lowest-index-first priority encoder for the eligible interrupt set.
//   Ports:
//     req    in  NUM_IRQ  request vector (PENDING & MASK)
//     valid  out 1        at least one request set
//     id     out 4        index of the lowest set request (0 when none)
//     onehot out NUM_IRQ  the winning request as a one-hot vector
// -----------------------------------------------------------------------------
module irq_prio_enc #(
    parameter int unsigned NUM_IRQ = 8
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic               valid,
    output logic [3:0]         id,
    output logic [NUM_IRQ-1:0] onehot
);

    // Scanning downwards lets the lowest set index overwrite any higher one.
    always_comb begin
        id = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (req[i]) id = 4'(i);
        end
    end

    assign valid  = |req;
    // Two's-complement trick isolates the lowest set bit.
    assign onehot = req & (~req + NUM_IRQ'(1));

endmodule

// File: rtl/cp0_irq_ctrl.sv
// -----------------------------------------------------------------------------
// cp0_irq_ctrl
//   CP0 register file with a multi-line vectored interrupt controller,
//   free-running COUNT with COMPARE-match timer interrupt, and ERET.
//   Reads are combinational (ID), writes/ERET commit at the clock edge (EXE),
//   interrupt arbitration looks at the current registered state (MEM).
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     oper              EXE_CP_STORE / EXE_CP0_ERET / no-op
//     addr_r, data_r    combinational register read
//     addr_w, data_w    register write (with oper = STORE)
//     ir_en             pipeline allows an interrupt this cycle
//     irq_in            level interrupt lines, rising edges latch PENDING
//     ret_addr          saved to EPC when an interrupt is taken
//     ir, ir_id         one-cycle "interrupt taken" pulse and its line id
//     jump_en/addr      forced-jump request to the fetch stage
// -----------------------------------------------------------------------------
module cp0_irq_ctrl
    import cp0_irq_ctrl_pkg::*;
#(
    parameter int unsigned NUM_IRQ    = 8,
    parameter int unsigned VECTORED   = 1,
    parameter int unsigned VEC_STRIDE = 32,
    parameter int unsigned TIMER_EN   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         oper,
    input  logic [4:0]         addr_r,
    output logic [31:0]        data_r,
    input  logic [4:0]         addr_w,
    input  logic [31:0]        data_w,
    input  logic               ir_en,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [31:0]        ret_addr,
    output logic               ir,
    output logic [3:0]         ir_id,
    output logic               jump_en,
    output logic [31:0]        jump_addr
);

    logic [31:0]        regs_q [32];
    logic [31:0]        regs_d [32];
    logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
    logic               ir_q, ir_d;
    logic [3:0]         ir_id_q, ir_id_d;
    logic               jump_en_q, jump_en_d;
    logic [31:0]        jump_addr_q, jump_addr_d;

    logic [NUM_IRQ-1:0] pending, mask, eligible, edges;
    logic [NUM_IRQ-1:0] pend_clr, pend_set;
    logic [NUM_IRQ-1:0] enc_onehot;
    logic [3:0]         enc_id;
    logic               enc_valid;
    logic               is_eret, is_store, take, timer_hit;

    assign pending  = regs_q[CP0_CAUSE][CAUSE_PEND_LO +: NUM_IRQ];
    assign mask     = regs_q[CP0_STATUS][STATUS_MASK_LO +: NUM_IRQ];
    assign eligible = pending & mask;
    assign edges    = irq_in & ~irq_prev_q;

    assign is_eret  = (oper == EXE_CP0_ERET);
    assign is_store = (oper == EXE_CP_STORE);

    assign take = ir_en && regs_q[CP0_STATUS][STATUS_IE]
               && !regs_q[CP0_STATUS][STATUS_EXL] && enc_valid;

    assign timer_hit = (TIMER_EN != 0)
                    && (regs_q[CP0_COUNT] == regs_q[CP0_COMPARE])
                    && (regs_q[CP0_COMPARE] != 32'd0);

    irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio_enc (
        .req    (eligible),
        .valid  (enc_valid),
        .id     (enc_id),
        .onehot (enc_onehot)
    );

    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        regs_d      = regs_q;
        irq_prev_d  = irq_in;
        ir_d        = 1'b0;
        ir_id_d     = '0;
        jump_en_d   = 1'b0;
        jump_addr_d = '0;
        pend_clr    = '0;
        pend_set    = edges;

        if (TIMER_EN != 0) begin
            regs_d[CP0_COUNT] = regs_q[CP0_COUNT] + 32'd1;
            pend_set[NUM_IRQ-1] = edges[NUM_IRQ-1] | timer_hit;
        end

        if (is_eret) begin
            jump_en_d   = 1'b1;
            jump_addr_d = regs_q[CP0_EPC];
            regs_d[CP0_STATUS][STATUS_EXL] = 1'b0;
        end else if (is_store) begin
            // CAUSE is write-1-to-clear on PENDING only; the id field and
            // remaining bits are owned by the controller.
            if (addr_w == CP0_CAUSE) begin
                pend_clr = data_w[CAUSE_PEND_LO +: NUM_IRQ];
            end else begin
                regs_d[addr_w] = data_w;   // a COUNT write overrides the increment
            end
            if ((TIMER_EN != 0) && (addr_w == CP0_COMPARE)) begin
                pend_clr[NUM_IRQ-1] = 1'b1;
            end
        end else if (take) begin
            ir_d        = 1'b1;
            ir_id_d     = enc_id;
            jump_en_d   = 1'b1;
            jump_addr_d = regs_q[CP0_EHBR]
                        + ((VECTORED != 0) ? 32'(enc_id) * 32'(VEC_STRIDE) : 32'd0);
            regs_d[CP0_EPC]                    = ret_addr;
            regs_d[CP0_STATUS][STATUS_EXL]     = 1'b1;
            regs_d[CP0_CAUSE][CAUSE_ID_LO +: 4] = enc_id;
            pend_clr = enc_onehot;
        end

        // New edges and timer matches win over any clear in the same cycle.
        regs_d[CP0_CAUSE][CAUSE_PEND_LO +: NUM_IRQ] = (pending & ~pend_clr) | pend_set;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the register array is reset explicitly because software
            // relies on STATUS/CAUSE/COUNT reading zero after reset.
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
            irq_prev_q  <= '0;
            ir_q        <= 1'b0;
            ir_id_q     <= '0;
            jump_en_q   <= 1'b0;
            jump_addr_q <= '0;
        end else begin
            regs_q      <= regs_d;
            irq_prev_q  <= irq_prev_d;
            ir_q        <= ir_d;
            ir_id_q     <= ir_id_d;
            jump_en_q   <= jump_en_d;
            jump_addr_q <= jump_addr_d;
        end
    end

    assign data_r    = regs_q[addr_r];
    assign ir        = ir_q;
    assign ir_id     = ir_id_q;
    assign jump_en   = jump_en_q;
    assign jump_addr = jump_addr_q;

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cp0_irq_ctrl
//   Directed scenarios followed by a randomized phase; every cycle the DUT's
//   outputs and the selected read port are compared to a behavioural model.
// -----------------------------------------------------------------------------
module tb_cp0_irq_ctrl;
    import cp0_irq_ctrl_pkg::*;

    localparam int N = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    oper;
    logic [4:0]    addr_r, addr_w;
    logic [31:0]   data_r, data_w;
    logic          ir_en;
    logic [N-1:0]  irq_in;
    logic [31:0]   ret_addr;
    logic          ir;
    logic [3:0]    ir_id;
    logic          jump_en;
    logic [31:0]   jump_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cp0_irq_ctrl #(.NUM_IRQ(N), .VECTORED(1), .VEC_STRIDE(32), .TIMER_EN(1)) dut (
        .clk(clk), .rst(rst), .oper(oper),
        .addr_r(addr_r), .data_r(data_r),
        .addr_w(addr_w), .data_w(data_w),
        .ir_en(ir_en), .irq_in(irq_in), .ret_addr(ret_addr),
        .ir(ir), .ir_id(ir_id), .jump_en(jump_en), .jump_addr(jump_addr)
    );

    // ---------------- reference model ----------------
    logic [31:0]  m_reg [32];
    logic [N-1:0] m_prev;
    logic         m_ir, m_jen;
    logic [3:0]   m_id;
    logic [31:0]  m_jaddr;

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_update();
        logic [31:0]  nx [32];
        logic [N-1:0] pend, elig;
        int           first;
        bit           take;
        if (rst) begin
            for (int i = 0; i < 32; i++) m_reg[i] = '0;
            m_prev = '0; m_ir = 0; m_id = '0; m_jen = 0; m_jaddr = '0;
            return;
        end
        nx    = m_reg;
        pend  = m_reg[CP0_CAUSE][16 +: N];
        elig  = pend & m_reg[CP0_STATUS][16 +: N];
        first = 0;
        while (first < N && !elig[first]) first++;
        take  = ir_en && m_reg[CP0_STATUS][0] && !m_reg[CP0_STATUS][1] && (first < N);
        nx[CP0_COUNT] = m_reg[CP0_COUNT] + 32'd1;
        m_ir = 0; m_id = '0; m_jen = 0; m_jaddr = '0;
        if (oper == EXE_CP0_ERET) begin
            m_jen = 1; m_jaddr = m_reg[CP0_EPC]; nx[CP0_STATUS][1] = 1'b0;
        end else if (oper == EXE_CP_STORE) begin
            if (addr_w == CP0_CAUSE) pend = pend & ~data_w[16 +: N];
            else nx[addr_w] = data_w;
            if (addr_w == CP0_COMPARE) pend[N-1] = 1'b0;
        end else if (take) begin
            m_ir = 1; m_id = 4'(first); m_jen = 1;
            m_jaddr = m_reg[CP0_EHBR] + 32'(first) * 32'd32;
            nx[CP0_EPC] = ret_addr;
            nx[CP0_STATUS][1] = 1'b1;
            nx[CP0_CAUSE][5:2] = 4'(first);
            pend[first] = 1'b0;
        end
        pend = pend | (irq_in & ~m_prev);
        if (m_reg[CP0_COMPARE] != 0 && m_reg[CP0_COUNT] == m_reg[CP0_COMPARE]) pend[N-1] = 1'b1;
        nx[CP0_CAUSE][16 +: N] = pend;
        m_prev = irq_in;
        m_reg  = nx;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        chk("ir", 32'(ir), 32'(m_ir));
        chk("ir_id", 32'(ir_id), 32'(m_id));
        chk("jump_en", 32'(jump_en), 32'(m_jen));
        chk("jump_addr", jump_addr, m_jaddr);
        chk("data_r", data_r, m_reg[addr_r]);
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        addr_r = a;
        #1;
        v = data_r;
    endtask

    task automatic store(input logic [4:0] a, input logic [31:0] d);
        oper = EXE_CP_STORE; addr_w = a; data_w = d;
        step();
        oper = EXE_CP_NONE;
    endtask

    task automatic eret();
        oper = EXE_CP0_ERET;
        step();
        oper = EXE_CP_NONE;
    endtask

    logic [31:0] v, epc_saved;
    int          r;
    bit          seen;

    initial begin
        rst = 1'b1; oper = EXE_CP_NONE; addr_r = '0; addr_w = '0; data_w = '0;
        ir_en = 1'b1; irq_in = '0; ret_addr = 32'h1234_0000;

        // ---- reset ----
        step(); step();
        chk("reset_ir", 32'(ir), 32'd0);
        chk("reset_jump_en", 32'(jump_en), 32'd0);
        chk("reset_jump_addr", jump_addr, 32'd0);
        rd(CP0_STATUS, v); chk("reset_status", v, 32'd0);
        rst = 1'b0;

        // ---- single line, vectored ----
        store(CP0_STATUS, 32'h00FF_0001);
        store(CP0_EHBR, 32'h0000_0100);
        irq_in = 8'h08; step();
        irq_in = 8'h00; step();
        chk("irq3_ir", 32'(ir), 32'd1);
        chk("irq3_id", 32'(ir_id), 32'd3);
        chk("irq3_jump_en", 32'(jump_en), 32'd1);
        chk("irq3_addr", jump_addr, 32'h0000_0160);
        rd(CP0_EPC, v);    chk("irq3_epc", v, 32'h1234_0000);
        rd(CP0_STATUS, v); chk("irq3_exl", 32'(v[1]), 32'd1);
        rd(CP0_CAUSE, v);  chk("irq3_pend_clr", 32'(v[19]), 32'd0);
        chk("irq3_cause_id", 32'(v[5:2]), 32'd3);
        step();
        chk("irq3_pulse_ir", 32'(ir), 32'd0);
        chk("irq3_pulse_jen", 32'(jump_en), 32'd0);

        // ---- two lines same cycle, priority, ERET ----
        eret();
        chk("eret1_addr", jump_addr, 32'h1234_0000);
        irq_in = 8'h24; step();
        irq_in = 8'h00; ret_addr = 32'h2000_0000; step();
        chk("prio_id2", 32'(ir_id), 32'd2);
        chk("prio_addr2", jump_addr, 32'h0000_0140);
        step();
        chk("exl_blocks", 32'(jump_en), 32'd0);
        eret();
        chk("eret2_addr", jump_addr, 32'h2000_0000);
        chk("eret2_ir", 32'(ir), 32'd0);
        step();
        chk("prio_id5", 32'(ir_id), 32'd5);
        chk("prio_addr5", jump_addr, 32'h0000_01A0);
        eret();

        // ---- timer match ----
        store(CP0_COUNT, 32'd10);
        store(CP0_COMPARE, 32'd20);
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step();
            if (ir) seen = 1;
        end
        chk("timer_taken", 32'(seen), 32'd1);
        chk("timer_id", 32'(ir_id), 32'd7);
        chk("timer_addr", jump_addr, 32'h0000_01E0);
        eret();

        // ---- COMPARE rewrite clears the timer pending bit ----
        ir_en = 1'b0;
        store(CP0_COUNT, 32'd25);
        store(CP0_COMPARE, 32'd30);
        repeat (6) step();
        rd(CP0_CAUSE, v); chk("timer_pend_set", 32'(v[23]), 32'd1);
        store(CP0_COMPARE, 32'h0000_1000);
        rd(CP0_CAUSE, v); chk("timer_pend_clr", 32'(v[23]), 32'd0);
        ir_en = 1'b1; step(); step();
        chk("timer_no_jump", 32'(jump_en), 32'd0);

        // ---- STORE vs take, ERET vs take ----
        irq_in = 8'h02; step();
        irq_in = 8'h00;
        store(CP0_EHBR, 32'h0000_0200);
        chk("store_wins_jen", 32'(jump_en), 32'd0);
        chk("store_wins_ir", 32'(ir), 32'd0);
        step();
        chk("deferred_id1", 32'(ir_id), 32'd1);
        chk("deferred_addr", jump_addr, 32'h0000_0220);
        rd(CP0_EPC, epc_saved);
        eret();
        irq_in = 8'h40; step();
        irq_in = 8'h00;
        eret();   // EXL already 0 and line 6 eligible: ERET must still win
        chk("eret_wins_ir", 32'(ir), 32'd0);
        chk("eret_wins_addr", jump_addr, epc_saved);
        rd(CP0_STATUS, v); chk("eret_exl0_stays", 32'(v[1]), 32'd0);
        step();
        chk("after_eret_id6", 32'(ir_id), 32'd6);
        chk("after_eret_addr", jump_addr, 32'h0000_02C0);
        eret();

        // ---- IE / ir_en gating, CAUSE write-1-to-clear ----
        store(CP0_STATUS, 32'h00FF_0000);
        irq_in = 8'h02; step();
        irq_in = 8'h00; step(); step();
        chk("ie0_no_jump", 32'(jump_en), 32'd0);
        ir_en = 1'b0;
        store(CP0_STATUS, 32'h00FF_0001);
        step();
        chk("iren0_no_jump", 32'(jump_en), 32'd0);
        ir_en = 1'b1; step();
        chk("enable_jump", 32'(jump_en), 32'd1);
        chk("enable_id", 32'(ir_id), 32'd1);
        eret();
        ir_en = 1'b0;
        irq_in = 8'h02; step();
        irq_in = 8'h00;
        store(CP0_CAUSE, 32'h0002_0000);
        ir_en = 1'b1; step();
        chk("w1c_no_jump", 32'(jump_en), 32'd0);
        rd(CP0_CAUSE, v); chk("w1c_pending", 32'(v[23:16]), 32'd0);

        // ---- reset mid-handler ----
        irq_in = 8'h08; step();
        irq_in = 8'h00; step();
        irq_in = 8'h0C; step();
        rd(CP0_CAUSE, v); chk("mid_pending", 32'(v[23:16]), 32'h0C);
        rd(CP0_STATUS, v); chk("mid_exl", 32'(v[1]), 32'd1);
        rst = 1'b1; irq_in = 8'h00; step();
        chk("rst_ir", 32'(ir), 32'd0);
        chk("rst_jen", 32'(jump_en), 32'd0);
        rd(CP0_STATUS, v); chk("rst_status", v, 32'd0);
        rd(CP0_CAUSE, v);  chk("rst_cause", v, 32'd0);
        rd(CP0_COUNT, v);  chk("rst_count", v, 32'd0);
        rst = 1'b0; step();
        rd(CP0_COUNT, v);  chk("count_restart", v, 32'd1);

        // ---- randomized phase against the model ----
        store(CP0_STATUS, 32'h00FF_0001);
        store(CP0_EHBR, 32'h0000_4000);
        for (int c = 0; c < 600; c++) begin
            irq_in   = irq_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            ir_en    = ($urandom_range(0, 3) != 0);
            ret_addr = $urandom;
            addr_r   = 5'($urandom);
            r        = $urandom_range(0, 15);
            oper     = EXE_CP_NONE;
            if (r == 0) begin
                oper = EXE_CP0_ERET;
            end else if (r <= 3) begin
                oper = EXE_CP_STORE;
                case ($urandom_range(0, 6))
                    0: begin addr_w = CP0_STATUS;
                             data_w = {8'h00, 8'($urandom), 14'h0, 1'($urandom), 1'b1}; end
                    1: begin addr_w = CP0_CAUSE;   data_w = $urandom; end
                    2: begin addr_w = CP0_COMPARE; data_w = m_reg[CP0_COUNT] + $urandom_range(2, 20); end
                    3: begin addr_w = CP0_COUNT;   data_w = $urandom; end
                    4: begin addr_w = CP0_EHBR;    data_w = $urandom; end
                    5: begin addr_w = CP0_EPC;     data_w = $urandom; end
                    default: begin addr_w = 5'($urandom); data_w = $urandom; end
                endcase
                // Leave a COMPARE write colliding with a match in the same cycle unexercised.
                if (addr_w == CP0_COMPARE && m_reg[CP0_COMPARE] != 0
                    && m_reg[CP0_COUNT] == m_reg[CP0_COMPARE]) oper = EXE_CP_NONE;
            end
            step();
        end
        oper = EXE_CP_NONE;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
